// File: rtl/fifo_param_if.sv
// Handshake and status bundle between a fifo_param instance and its user.
// The user side takes the master modport and the FIFO takes the slave modport.
interface fifo_param_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5
);
    logic              iPush;
    logic [DATA_W-1:0] iWrData;
    logic              iPop;
    logic              iClrErr;
    logic [DATA_W-1:0] oRdData;
    logic              oRdValid;
    logic              oFull;
    logic              oEmpty;
    logic              oAlmostFull;
    logic              oAlmostEmpty;
    logic [ADDR_W:0]   oCount;
    logic              oOverflow;
    logic              oUnderflow;

    modport master (
        output iPush, iWrData, iPop, iClrErr,
        input  oRdData, oRdValid, oFull, oEmpty, oAlmostFull, oAlmostEmpty,
               oCount, oOverflow, oUnderflow
    );

    modport slave (
        input  iPush, iWrData, iPop, iClrErr,
        output oRdData, oRdValid, oFull, oEmpty, oAlmostFull, oAlmostEmpty,
               oCount, oOverflow, oUnderflow
    );
endinterface

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a selectable read mode
// (registered read, or first-word-fall-through when FWFT != 0).
module fifo_param #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned AFULL_TH  = 28,
    parameter int unsigned AEMPTY_TH = 4,
    parameter int unsigned FWFT      = 0
) (
    input logic         iClk,
    input logic         iRst,
    fifo_param_if.slave bus
);
    localparam int unsigned     DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] AFULL_C  = AFULL_TH[ADDR_W:0];
    localparam logic [ADDR_W:0] AEMPTY_C = AEMPTY_TH[ADDR_W:0];

    logic [DATA_W-1:0] mem_q [DEPTH];

    // One extra pointer bit so the pointers wrap modulo 2*DEPTH.
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0] count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            udf_q, udf_d;

    logic full;
    logic empty;
    logic rd_acc;
    logic wr_acc;

    // Status flags decode straight from the count register.
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
    assign rd_acc = bus.iPop & ~empty;
    assign wr_acc = bus.iPush & (~full | rd_acc);

    assign bus.oFull        = full;
    assign bus.oEmpty       = empty;
    assign bus.oAlmostFull  = (count_q >= AFULL_C);
    assign bus.oAlmostEmpty = (count_q <= AEMPTY_C);
    assign bus.oCount       = count_q;
    assign bus.oOverflow    = ovf_q;
    assign bus.oUnderflow   = udf_q;

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A new error in the same cycle as a clear keeps the flag set.
        ovf_d = (ovf_q & ~bus.iClrErr) | (bus.iPush & ~wr_acc);
        udf_d = (udf_q & ~bus.iClrErr) | (bus.iPop & ~rd_acc);
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage write; contents are never reset, reset only blocks the write.
    always_ff @(posedge iClk) begin
        if (wr_acc && !iRst) mem_q[wr_ptr_q[ADDR_W-1:0]] <= bus.iWrData;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown directly; zero when there is nothing to show.
            assign bus.oRdData  = empty ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];
            assign bus.oRdValid = ~empty;
        end else begin : g_reg
            logic [DATA_W-1:0] rd_data_q;
            logic              rd_valid_q;

            // Registered read: the popped word lands one cycle after the pop.
            // In the full+push+pop case this samples the pre-write word.
            always_ff @(posedge iClk) begin
                if (iRst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) rd_data_q <= mem_q[rd_ptr_q[ADDR_W-1:0]];
                end
            end

            assign bus.oRdData  = rd_data_q;
            assign bus.oRdValid = rd_valid_q;
        end
    endgenerate
endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: one registered-read instance with default parameters
// and one FWFT instance (16-bit, depth 8), each shadowed by a queue model.
module tb_fifo_param;
    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fifo_param_if #(.DATA_W(8),  .ADDR_W(5)) b0 ();
    fifo_param_if #(.DATA_W(16), .ADDR_W(3)) b1 ();

    fifo_param #(.DATA_W(8), .ADDR_W(5), .AFULL_TH(28), .AEMPTY_TH(4), .FWFT(0))
        dut0 (.iClk(clk), .iRst(rst0), .bus(b0));
    fifo_param #(.DATA_W(16), .ADDR_W(3), .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(1))
        dut1 (.iClk(clk), .iRst(rst1), .bus(b1));

    // Reference model state.
    logic [7:0]  q0[$];
    logic [7:0]  m0_rd;
    bit          m0_vld, m0_ovf, m0_udf;
    logic [15:0] q1[$];
    bit          m1_ovf, m1_udf;

    // Drive one cycle on instance 0 and advance the model; sample point is edge+1.
    task automatic cycle0(input bit push, input bit pop, input bit clr, input bit rst,
                          input logic [7:0] d);
        bit pop_ok, push_ok, was_full;
        b0.iPush = push; b0.iPop = pop; b0.iClrErr = clr; b0.iWrData = d; rst0 = rst;
        @(posedge clk);
        #1;
        if (rst) begin
            q0.delete(); m0_rd = '0; m0_vld = 0; m0_ovf = 0; m0_udf = 0;
        end else begin
            was_full = (q0.size() == 32);
            pop_ok   = pop && (q0.size() != 0);
            push_ok  = push && (!was_full || pop_ok);
            m0_vld   = pop_ok;
            if (pop_ok)  m0_rd = q0.pop_front();
            if (push_ok) q0.push_back(d);
            m0_ovf = (m0_ovf && !clr) || (push && !push_ok);
            m0_udf = (m0_udf && !clr) || (pop && !pop_ok);
        end
        b0.iPush = 0; b0.iPop = 0; b0.iClrErr = 0; rst0 = 0;
    endtask

    task automatic cycle1(input bit push, input bit pop, input bit clr, input bit rst,
                          input logic [15:0] d);
        bit pop_ok, push_ok, was_full;
        b1.iPush = push; b1.iPop = pop; b1.iClrErr = clr; b1.iWrData = d; rst1 = rst;
        @(posedge clk);
        #1;
        if (rst) begin
            q1.delete(); m1_ovf = 0; m1_udf = 0;
        end else begin
            was_full = (q1.size() == 8);
            pop_ok   = pop && (q1.size() != 0);
            push_ok  = push && (!was_full || pop_ok);
            if (pop_ok)  void'(q1.pop_front());
            if (push_ok) q1.push_back(d);
            m1_ovf = (m1_ovf && !clr) || (push && !push_ok);
            m1_udf = (m1_udf && !clr) || (pop && !pop_ok);
        end
        b1.iPush = 0; b1.iPop = 0; b1.iClrErr = 0; rst1 = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            if (i < 2) cycle0(0, 0, 0, 1, 8'h00);
            else       cycle0(0, 0, 0, 0, 8'h00);
            checks++;
            if (b0.oCount !== 6'd0 || b0.oEmpty !== 1'b1 || b0.oAlmostEmpty !== 1'b1 ||
                b0.oFull !== 1'b0 || b0.oAlmostFull !== 1'b0 || b0.oRdValid !== 1'b0 ||
                b0.oRdData !== 8'h00 || b0.oOverflow !== 1'b0 || b0.oUnderflow !== 1'b0) begin
                errors++;
                $display("FAIL reset_state cyc%0d: got cnt=%0d e=%b ae=%b f=%b af=%b v=%b d=%h ov=%b un=%b, exp cnt=0 e=1 ae=1 f=0 af=0 v=0 d=00 ov=0 un=0",
                         i, b0.oCount, b0.oEmpty, b0.oAlmostEmpty, b0.oFull, b0.oAlmostFull,
                         b0.oRdValid, b0.oRdData, b0.oOverflow, b0.oUnderflow);
            end
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 32; i++) begin
            cycle0(1, 0, 0, 0, 8'(i));
            checks++;
            if (b0.oCount !== 6'(i + 1) || b0.oAlmostFull !== (i + 1 >= 28) ||
                b0.oFull !== (i + 1 == 32) || b0.oAlmostEmpty !== (i + 1 <= 4) ||
                b0.oEmpty !== 1'b0) begin
                errors++;
                $display("FAIL fill_flags push%0d: got cnt=%0d af=%b f=%b ae=%b e=%b, exp cnt=%0d af=%b f=%b ae=%b e=0",
                         i, b0.oCount, b0.oAlmostFull, b0.oFull, b0.oAlmostEmpty, b0.oEmpty,
                         i + 1, (i + 1 >= 28), (i + 1 == 32), (i + 1 <= 4));
            end
        end
        cycle0(1, 0, 0, 0, 8'hAA);
        checks++;
        if (b0.oOverflow !== 1'b1 || b0.oCount !== 6'd32 || b0.oFull !== 1'b1) begin
            errors++;
            $display("FAIL overflow_push: got ov=%b cnt=%0d f=%b, exp ov=1 cnt=32 f=1",
                     b0.oOverflow, b0.oCount, b0.oFull);
        end
        for (int i = 0; i < 32; i++) begin
            cycle0(0, 1, 0, 0, 8'h00);
            checks++;
            if (b0.oRdData !== 8'(i) || b0.oRdValid !== 1'b1 || b0.oCount !== 6'(31 - i)) begin
                errors++;
                $display("FAIL drain_data pop%0d: got d=%h v=%b cnt=%0d, exp d=%h v=1 cnt=%0d",
                         i, b0.oRdData, b0.oRdValid, b0.oCount, 8'(i), 31 - i);
            end
        end
        cycle0(0, 0, 0, 0, 8'h00);
        checks++;
        if (b0.oRdValid !== 1'b0 || b0.oRdData !== 8'h1F || b0.oEmpty !== 1'b1) begin
            errors++;
            $display("FAIL drain_idle: got v=%b d=%h e=%b, exp v=0 d=1f e=1",
                     b0.oRdValid, b0.oRdData, b0.oEmpty);
        end
    endtask

    task automatic test_empty_pop_clear();
        cycle0(0, 1, 0, 0, 8'h00);
        checks++;
        if (b0.oUnderflow !== 1'b1 || b0.oCount !== 6'd0 || b0.oRdData !== 8'h1F ||
            b0.oRdValid !== 1'b0) begin
            errors++;
            $display("FAIL empty_pop: got un=%b cnt=%0d d=%h v=%b, exp un=1 cnt=0 d=1f v=0",
                     b0.oUnderflow, b0.oCount, b0.oRdData, b0.oRdValid);
        end
        cycle0(0, 0, 1, 0, 8'h00);
        checks++;
        if (b0.oOverflow !== 1'b0 || b0.oUnderflow !== 1'b0) begin
            errors++;
            $display("FAIL clr_err: got ov=%b un=%b, exp ov=0 un=0", b0.oOverflow, b0.oUnderflow);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] head;
        for (int i = 0; i < 32; i++) cycle0(1, 0, 0, 0, 8'($urandom));
        head = q0[0];
        cycle0(1, 1, 0, 0, 8'h55);
        checks++;
        if (b0.oCount !== 6'd32 || b0.oOverflow !== 1'b0 || b0.oRdData !== head ||
            b0.oRdValid !== 1'b1) begin
            errors++;
            $display("FAIL full_push_pop: got cnt=%0d ov=%b d=%h v=%b, exp cnt=32 ov=0 d=%h v=1",
                     b0.oCount, b0.oOverflow, b0.oRdData, b0.oRdValid, head);
        end
        for (int i = 0; i < 32; i++) cycle0(0, 1, 0, 0, 8'h00);
        checks++;
        if (b0.oRdData !== 8'h55 || b0.oEmpty !== 1'b1) begin
            errors++;
            $display("FAIL full_push_pop_tail: got d=%h e=%b, exp d=55 e=1", b0.oRdData, b0.oEmpty);
        end
        cycle0(1, 1, 0, 0, 8'h66);
        checks++;
        if (b0.oCount !== 6'd1 || b0.oUnderflow !== 1'b1 || b0.oRdValid !== 1'b0) begin
            errors++;
            $display("FAIL empty_push_pop: got cnt=%0d un=%b v=%b, exp cnt=1 un=1 v=0",
                     b0.oCount, b0.oUnderflow, b0.oRdValid);
        end
        cycle0(0, 1, 0, 0, 8'h00);
        checks++;
        if (b0.oRdData !== 8'h66 || b0.oRdValid !== 1'b1) begin
            errors++;
            $display("FAIL empty_push_pop_data: got d=%h v=%b, exp d=66 v=1", b0.oRdData, b0.oRdValid);
        end
        cycle0(0, 1, 1, 0, 8'h00);
        checks++;
        if (b0.oUnderflow !== 1'b1) begin
            errors++;
            $display("FAIL clr_vs_new_err: got un=%b, exp un=1", b0.oUnderflow);
        end
        cycle0(0, 0, 1, 0, 8'h00);
        for (int i = 0; i < 10; i++) cycle0(1, 0, 0, 0, 8'(8'h30 + i));
        cycle0(1, 1, 0, 0, 8'h77);
        checks++;
        if (b0.oCount !== 6'd10 || b0.oRdData !== 8'h30 || b0.oOverflow !== 1'b0 ||
            b0.oUnderflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_push_pop: got cnt=%0d d=%h ov=%b un=%b, exp cnt=10 d=30 ov=0 un=0",
                     b0.oCount, b0.oRdData, b0.oOverflow, b0.oUnderflow);
        end
    endtask

    task automatic test_mid_reset();
        while (q0.size() < 17) cycle0(1, 0, 0, 0, 8'($urandom));
        cycle0(0, 1, 1, 0, 8'h00);
        cycle0(1, 0, 0, 0, 8'hC3);
        checks++;
        if (b0.oCount !== 6'd17) begin
            errors++;
            $display("FAIL mid_reset_pre: got cnt=%0d, exp 17", b0.oCount);
        end
        cycle0(1, 1, 0, 1, 8'hEE);
        checks++;
        if (b0.oCount !== 6'd0 || b0.oEmpty !== 1'b1 || b0.oOverflow !== 1'b0 ||
            b0.oUnderflow !== 1'b0 || b0.oRdValid !== 1'b0 || b0.oRdData !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: got cnt=%0d e=%b ov=%b un=%b v=%b d=%h, exp cnt=0 e=1 ov=0 un=0 v=0 d=00",
                     b0.oCount, b0.oEmpty, b0.oOverflow, b0.oUnderflow, b0.oRdValid, b0.oRdData);
        end
        cycle0(1, 0, 0, 0, 8'h11);
        cycle0(1, 0, 0, 0, 8'h22);
        cycle0(0, 1, 0, 0, 8'h00);
        checks++;
        if (b0.oRdData !== 8'h11 || b0.oCount !== 6'd1) begin
            errors++;
            $display("FAIL post_reset_pop1: got d=%h cnt=%0d, exp d=11 cnt=1", b0.oRdData, b0.oCount);
        end
        cycle0(0, 1, 0, 0, 8'h00);
        checks++;
        if (b0.oRdData !== 8'h22 || b0.oEmpty !== 1'b1 || b0.oUnderflow !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_pop2: got d=%h e=%b un=%b, exp d=22 e=1 un=0",
                     b0.oRdData, b0.oEmpty, b0.oUnderflow);
        end
    endtask

    task automatic test_random0();
        logic [5:0] exp_cnt;
        bit push, pop;
        for (int i = 0; i < 2000; i++) begin
            if (((i / 150) % 2) == 0) begin
                push = ($urandom_range(99) < 75); pop = ($urandom_range(99) < 35);
            end else begin
                push = ($urandom_range(99) < 35); pop = ($urandom_range(99) < 75);
            end
            cycle0(push, pop, ($urandom_range(99) < 5), ($urandom_range(499) == 0), 8'($urandom));
            exp_cnt = 6'(q0.size());
            checks++;
            if (b0.oCount !== exp_cnt || b0.oFull !== (exp_cnt == 6'd32) ||
                b0.oEmpty !== (exp_cnt == 6'd0) || b0.oAlmostFull !== (exp_cnt >= 6'd28) ||
                b0.oAlmostEmpty !== (exp_cnt <= 6'd4) || b0.oOverflow !== m0_ovf ||
                b0.oUnderflow !== m0_udf || b0.oRdValid !== m0_vld) begin
                errors++;
                $display("FAIL rand0_status cyc%0d: got cnt=%0d f=%b e=%b af=%b ae=%b ov=%b un=%b v=%b, exp cnt=%0d ov=%b un=%b v=%b",
                         i, b0.oCount, b0.oFull, b0.oEmpty, b0.oAlmostFull, b0.oAlmostEmpty,
                         b0.oOverflow, b0.oUnderflow, b0.oRdValid, exp_cnt, m0_ovf, m0_udf, m0_vld);
            end
            checks++;
            if (b0.oRdData !== m0_rd) begin
                errors++;
                $display("FAIL rand0_data cyc%0d: got %h, exp %h", i, b0.oRdData, m0_rd);
            end
        end
    endtask

    task automatic test_fwft();
        cycle1(0, 0, 0, 1, 16'h0000);
        checks++;
        if (b1.oRdValid !== 1'b0 || b1.oRdData !== 16'h0000 || b1.oEmpty !== 1'b1) begin
            errors++;
            $display("FAIL fwft_reset: got v=%b d=%h e=%b, exp v=0 d=0000 e=1",
                     b1.oRdValid, b1.oRdData, b1.oEmpty);
        end
        cycle1(1, 0, 0, 0, 16'hBEEF);
        checks++;
        if (b1.oRdData !== 16'hBEEF || b1.oRdValid !== 1'b1 || b1.oCount !== 4'd1) begin
            errors++;
            $display("FAIL fwft_first_word: got d=%h v=%b cnt=%0d, exp d=beef v=1 cnt=1",
                     b1.oRdData, b1.oRdValid, b1.oCount);
        end
        cycle1(1, 0, 0, 0, 16'h1234);
        cycle1(0, 1, 0, 0, 16'h0000);
        checks++;
        if (b1.oRdData !== 16'h1234 || b1.oRdValid !== 1'b1) begin
            errors++;
            $display("FAIL fwft_next_word: got d=%h v=%b, exp d=1234 v=1", b1.oRdData, b1.oRdValid);
        end
        cycle1(0, 1, 0, 0, 16'h0000);
        checks++;
        if (b1.oEmpty !== 1'b1 || b1.oRdData !== 16'h0000 || b1.oRdValid !== 1'b0) begin
            errors++;
            $display("FAIL fwft_empty: got e=%b d=%h v=%b, exp e=1 d=0000 v=0",
                     b1.oEmpty, b1.oRdData, b1.oRdValid);
        end
        for (int i = 0; i < 9; i++) cycle1(1, 0, 0, 0, 16'(16'hA000 + i));
        checks++;
        if (b1.oFull !== 1'b1 || b1.oCount !== 4'd8 || b1.oOverflow !== 1'b1 ||
            b1.oRdData !== 16'hA000) begin
            errors++;
            $display("FAIL fwft_full: got f=%b cnt=%0d ov=%b d=%h, exp f=1 cnt=8 ov=1 d=a000",
                     b1.oFull, b1.oCount, b1.oOverflow, b1.oRdData);
        end
    endtask

    task automatic test_random1();
        logic [3:0]  exp_cnt;
        logic [15:0] exp_d;
        bit push, pop;
        for (int i = 0; i < 1500; i++) begin
            if (((i / 60) % 2) == 0) begin
                push = ($urandom_range(99) < 70); pop = ($urandom_range(99) < 40);
            end else begin
                push = ($urandom_range(99) < 40); pop = ($urandom_range(99) < 70);
            end
            cycle1(push, pop, ($urandom_range(99) < 5), ($urandom_range(399) == 0), 16'($urandom));
            exp_cnt = 4'(q1.size());
            exp_d   = (q1.size() != 0) ? q1[0] : 16'h0000;
            checks++;
            if (b1.oCount !== exp_cnt || b1.oFull !== (exp_cnt == 4'd8) ||
                b1.oEmpty !== (exp_cnt == 4'd0) || b1.oAlmostFull !== (exp_cnt >= 4'd6) ||
                b1.oAlmostEmpty !== (exp_cnt <= 4'd2) || b1.oOverflow !== m1_ovf ||
                b1.oUnderflow !== m1_udf || b1.oRdValid !== (exp_cnt != 4'd0) ||
                b1.oRdData !== exp_d) begin
                errors++;
                $display("FAIL rand1 cyc%0d: got cnt=%0d f=%b e=%b af=%b ae=%b ov=%b un=%b v=%b d=%h, exp cnt=%0d ov=%b un=%b d=%h",
                         i, b1.oCount, b1.oFull, b1.oEmpty, b1.oAlmostFull, b1.oAlmostEmpty,
                         b1.oOverflow, b1.oUnderflow, b1.oRdValid, b1.oRdData,
                         exp_cnt, m1_ovf, m1_udf, exp_d);
            end
        end
    endtask

    initial begin
        b0.iPush = 0; b0.iPop = 0; b0.iClrErr = 0; b0.iWrData = '0;
        b1.iPush = 0; b1.iPop = 0; b1.iClrErr = 0; b1.iWrData = '0;
        m0_rd = '0; m0_vld = 0; m0_ovf = 0; m0_udf = 0; m1_ovf = 0; m1_udf = 0;
        #1;
        test_reset();
        test_fill_drain();
        test_empty_pop_clear();
        test_simultaneous();
        test_mid_reset();
        test_random0();
        test_fwft();
        test_random1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Parametrised synchronous FIFO; the next generation of the UART byte FIFO.
- Generalised in data width and depth.
- Adds an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and a selectable read mode: registered read or first-word-fall-through (FWFT).
- Sits between the UART RX/TX engines and sensor/command logic; one instance per direction.

Parameters:
- DATA_W, 8: data word width in bits.
- ADDR_W, 5: address width; depth DEPTH = 2**ADDR_W (32 by default).
- AFULL_TH, 28: oAlmostFull asserted when count >= AFULL_TH; legal range 1..DEPTH.
- AEMPTY_TH, 4: oAlmostEmpty asserted when count <= AEMPTY_TH; legal range 0..DEPTH-1.
- FWFT, 0: 0 = registered read mode; 1 = first-word-fall-through mode.

Ports:
- iClk, in, 1: clock; all logic on the rising edge.
- iRst, in, 1: synchronous, active-high reset.
- iPush, in, 1: write request.
- iWrData, in, DATA_W: write data, sampled with iPush.
- iPop, in, 1: read request.
- iClrErr, in, 1: clears the sticky error flags.
- oRdData, out, DATA_W: read data.
- oRdValid, out, 1: oRdData holds freshly popped data (FWFT=0) or a valid head word (FWFT=1).
- oFull, out, 1: count == DEPTH.
- oEmpty, out, 1: count == 0.
- oAlmostFull, out, 1: count >= AFULL_TH.
- oAlmostEmpty, out, 1: count <= AEMPTY_TH.
- oCount, out, ADDR_W+1: current occupancy, 0..DEPTH.
- oOverflow, out, 1: sticky; a push was rejected.
- oUnderflow, out, 1: sticky; a pop was rejected.

Behaviour:
- Storage: DEPTH x DATA_W memory with no reset on its contents.
- Pointers: write and read pointers are ADDR_W+1 bits and wrap modulo 2*DEPTH; the memory is indexed by the low ADDR_W bits.
- Count register: ADDR_W+1 bits; all status flags decode combinationally from it, so they are valid in the same cycle as oCount.
- Accepted push: wr_acc = iPush & (~oFull | rd_acc). The word is written at wr_ptr and wr_ptr increments.
- Accepted pop: rd_acc = iPop & ~oEmpty. rd_ptr increments.
- Simultaneous push and pop:
  - Full: both accepted; count stays DEPTH; no overflow flagged.
  - Empty: push accepted, pop rejected; count becomes 1; oUnderflow sets.
  - Otherwise: both accepted; count unchanged.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Rejected push (full, no accepted pop): data dropped, oOverflow <= 1.
- Rejected pop (empty): oUnderflow <= 1; pointers, count and oRdData unchanged.
- Error flags hold until iClrErr or iRst. If iClrErr coincides with a new error in the same cycle, the flag stays set.
- FWFT=0 mode:
  - On an accepted pop, oRdData <= mem[rd_ptr] at that edge, giving 1-cycle latency.
  - oRdValid is high for exactly the cycle after an accepted pop.
  - oRdData holds its value otherwise.
- FWFT=1 mode:
  - oRdData = mem[rd_ptr] combinationally whenever ~oEmpty, and 0 when empty.
  - oRdValid = ~oEmpty.
  - A pop consumes the displayed word; the next word appears the cycle after the pop edge.
  - A word pushed into an empty FIFO appears on oRdData the cycle after the push edge.
- Read-during-write to the same address cannot occur except through the full+push+pop case, where the pop reads the old word. Memory read returns pre-write data.
- Reset (iRst=1 at a rising edge), which overrides all requests in that cycle:
  - Pointers and count to 0; oRdData, oRdValid, oOverflow and oUnderflow to 0.
  - Resulting flags: oEmpty=1, oFull=0, oAlmostEmpty=1, oAlmostFull=0 (given AFULL_TH >= 1).
- Reset mid-operation discards all contents; no stale data is presented afterwards.

Test Plan (defaults unless stated):
- Reset then idle:
  - oCount=0, oEmpty=1, oAlmostEmpty=1, oFull=0, oRdValid=0, oRdData=0x00.
- Fill and drain (FWFT=0):
  - Push 0x00..0x1F on 32 consecutive cycles: oAlmostFull rises when oCount=28; oFull=1 at oCount=32.
  - A 33rd push of 0xAA sets oOverflow=1 and oCount stays 32.
  - Pop 32 times: oRdData returns 0x00..0x1F, each one cycle after its pop with oRdValid=1, confirming the pointers wrap.
- Empty pop and error clear:
  - Pop on an empty FIFO sets oUnderflow=1, oCount=0 and oRdData unchanged.
  - Pulse iClrErr: both error flags return to 0.
- Simultaneous push and pop:
  - At oCount=32, push 0x55 with pop: oCount stays 32 and oOverflow stays 0.
  - At oCount=0, push 0x66 with pop: oCount=1 and oUnderflow=1.
  - At oCount=10, push with pop: oCount stays 10.
- FWFT=1, DATA_W=16, ADDR_W=3:
  - Push 0xBEEF into the empty FIFO: the next cycle shows oRdData=0xBEEF, oRdValid=1.
  - Push 0x1234, then pop once: oRdData=0x1234.
  - Pop again: oEmpty=1 and oRdData=0x0000.
- Reset mid-operation:
  - With oCount=17, assert iRst for 1 cycle while iPush=1 and iPop=1: the next cycle shows oCount=0, oEmpty=1 and both error flags 0.
  - Following pushes and pops operate normally.
